// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: shared widths, frame field offsets, NeuralLink command codes
// and the frame-engine state encoding for the SPI command master.
package spi_cmd_pkg;

    localparam int SPI_CODE_LEN_DEF = 6;
    localparam int SPI_ADDR_LEN_DEF = 10;
    localparam int SPI_DATA_LEN_DEF = 16;
    localparam int LEN_SPI_DEF      = SPI_CODE_LEN_DEF + SPI_ADDR_LEN_DEF + SPI_DATA_LEN_DEF;

    localparam int DATA_OFS = 0;
    localparam int ADDR_OFS = SPI_DATA_LEN_DEF;
    localparam int CODE_OFS = SPI_DATA_LEN_DEF + SPI_ADDR_LEN_DEF;

    localparam logic [SPI_CODE_LEN_DEF-1:0] CMD_READ_STIM = 6'd3;
    localparam logic [SPI_CODE_LEN_DEF-1:0] CMD_WRITE_REC = 6'd4;
    localparam logic [SPI_CODE_LEN_DEF-1:0] CMD_CB_OK_LOW = 6'd18;
    localparam logic [SPI_CODE_LEN_DEF-1:0] CMD_READ_ADC  = 6'd19;
    localparam logic [SPI_CODE_LEN_DEF-1:0] CMD_CODE_MAX  = 6'd24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_TAIL,
        ST_GAP
    } state_t;

    // Packs a frame with CODE in the MSBs and DATA in the LSBs.
    function automatic logic [LEN_SPI_DEF-1:0] make_frame(
        input logic [SPI_CODE_LEN_DEF-1:0] code,
        input logic [SPI_ADDR_LEN_DEF-1:0] addr,
        input logic [SPI_DATA_LEN_DEF-1:0] data
    );
        return {code, addr, data};
    endfunction

endpackage

// File: rtl/spi_cmd_if.sv
// spi_cmd_if: command push / response bus between the host sequencer and
// the SPI command master.
interface spi_cmd_if
    import spi_cmd_pkg::*;
#(
    parameter int LEN_SPI = LEN_SPI_DEF,
    parameter int NUM_CS  = 1
);
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int PBW = $clog2(LEN_SPI);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [LEN_SPI-1:0] cmd_frame;
    logic [CSW-1:0]     cmd_cs_sel;
    logic               cmd_poll;
    logic [PBW-1:0]     cmd_poll_bit;
    logic               rsp_valid;
    logic [LEN_SPI-1:0] rsp_frame;
    logic               rsp_timeout;
    logic               busy;

    modport master (
        output cmd_valid, cmd_frame, cmd_cs_sel, cmd_poll, cmd_poll_bit,
        input  cmd_ready, rsp_valid, rsp_frame, rsp_timeout, busy
    );

    modport slave (
        input  cmd_valid, cmd_frame, cmd_cs_sel, cmd_poll, cmd_poll_bit,
        output cmd_ready, rsp_valid, rsp_frame, rsp_timeout, busy
    );

endinterface

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: small synchronous FIFO with show-ahead read data. Pointers
// carry one extra wrap bit so full and empty are told apart without a count.
module spi_cmd_fifo
    import spi_cmd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Advance the pointers; a push while full is dropped even if a pop happens too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array needs no reset; empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: shifts queued {CMD, ADDR, DATA} frames out LSB first with
// a divided SCK (idle high), captures MISO on each falling edge, and can
// re-issue a frame until a selected response bit reads back as 1.
module spi_cmd_master
    import spi_cmd_pkg::*;
#(
    parameter int SPI_CODE_LEN = SPI_CODE_LEN_DEF,
    parameter int SPI_ADDR_LEN = SPI_ADDR_LEN_DEF,
    parameter int SPI_DATA_LEN = SPI_DATA_LEN_DEF,
    parameter int LEN_SPI      = SPI_CODE_LEN + SPI_ADDR_LEN + SPI_DATA_LEN,
    parameter int CLK_DIV      = 5,
    parameter int NUM_CS       = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int POLL_MAX     = 255
) (
    input  logic              clk_50M,
    input  logic              rst,
    spi_cmd_if.slave          bus,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);
    localparam int CSW  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int PBW  = $clog2(LEN_SPI);
    localparam int DIVW = $clog2(CLK_DIV);
    localparam int ATW  = $clog2(POLL_MAX + 1);
    localparam int FW   = LEN_SPI + CSW + 1 + PBW;

    state_t             state;
    state_t             state_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [FW-1:0]      fifo_din;
    logic [FW-1:0]      fifo_dout;
    logic [LEN_SPI-1:0] work_frame;
    logic [LEN_SPI-1:0] tx;
    logic [LEN_SPI-1:0] rx;
    logic [LEN_SPI-1:0] rsp_frame;
    logic [CSW-1:0]     work_sel;
    logic               work_poll;
    logic [PBW-1:0]     work_bit;
    logic [PBW-1:0]     bit_idx;
    logic [DIVW-1:0]    div_cnt;
    logic [ATW-1:0]     attempts;
    logic [ATW-1:0]     attempts_inc;
    logic               retry;
    logic               rsp_valid;
    logic               rsp_timeout;
    logic               phase_end;
    logic               last_bit;
    logic               poll_hit;
    logic               poll_limit;
    logic               frame_done;
    logic [NUM_CS-1:0]  sel_mask;

    assign fifo_din      = {bus.cmd_frame, bus.cmd_cs_sel, bus.cmd_poll, bus.cmd_poll_bit};
    assign pop           = (state == ST_IDLE) && !fifo_empty;
    assign bus.cmd_ready = !fifo_full;
    assign bus.busy      = (state != ST_IDLE) || !fifo_empty;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_frame   = rsp_frame;
    assign bus.rsp_timeout = rsp_timeout;

    assign phase_end    = (div_cnt == DIVW'(CLK_DIV - 1));
    assign last_bit     = (bit_idx == PBW'(LEN_SPI - 1));
    assign attempts_inc = (attempts == ATW'(POLL_MAX)) ? attempts : attempts + 1'b1;
    assign poll_hit     = rx[work_bit];
    assign poll_limit   = (attempts_inc == ATW'(POLL_MAX));
    assign frame_done   = !work_poll || poll_hit || poll_limit;

    spi_cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_50M),
        .rst   (rst),
        .push  (bus.cmd_valid),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register; reset returns the engine to IDLE mid-frame.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Phase sequencing: every timed phase lasts CLK_DIV cycles.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!fifo_empty) state_next = ST_SETUP;
            ST_SETUP: if (phase_end) state_next = ST_LOW;
            ST_LOW:   if (phase_end) state_next = ST_HIGH;
            ST_HIGH:  if (phase_end) state_next = last_bit ? ST_TAIL : ST_LOW;
            ST_TAIL:  if (phase_end) state_next = ST_GAP;
            ST_GAP:   if (phase_end) state_next = retry ? ST_SETUP : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Decode the working chip-select index; out-of-range selects no line.
    always_comb begin
        sel_mask = '1;
        for (int k = 0; k < NUM_CS; k++) begin
            if (work_sel == CSW'(k)) sel_mask[k] = 1'b0;
        end
    end

    // Pin drive from state so reset idles the pins without waiting for a clock.
    always_comb begin
        sck  = 1'b1;
        mosi = 1'b0;
        cs_n = '1;
        case (state)
            ST_SETUP: begin
                mosi = work_frame[0];
                cs_n = sel_mask;
            end
            ST_LOW: begin
                sck  = 1'b0;
                mosi = tx[0];
                cs_n = sel_mask;
            end
            ST_HIGH: begin
                mosi = tx[0];
                cs_n = sel_mask;
            end
            ST_TAIL: cs_n = sel_mask;
            default: ;
        endcase
    end

    // Working registers, shift/capture datapath, attempt count and response.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            work_frame  <= '0;
            work_sel    <= '0;
            work_poll   <= 1'b0;
            work_bit    <= '0;
            tx          <= '0;
            rx          <= '0;
            bit_idx     <= '0;
            div_cnt     <= '0;
            attempts    <= '0;
            retry       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_frame   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            div_cnt   <= (phase_end || state == ST_IDLE) ? '0 : div_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {work_frame, work_sel, work_poll, work_bit} <= fifo_dout;
                        attempts <= '0;
                        retry    <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (phase_end) begin
                        tx      <= work_frame;
                        bit_idx <= '0;
                    end
                end
                ST_LOW: begin
                    if (div_cnt == '0) rx[bit_idx] <= miso;
                    if (phase_end)     tx <= tx >> 1;
                end
                ST_HIGH: begin
                    if (phase_end && !last_bit) bit_idx <= bit_idx + 1'b1;
                end
                ST_TAIL: begin
                    if (phase_end) begin
                        attempts <= attempts_inc;
                        retry    <= !frame_done;
                        if (frame_done) begin
                            rsp_valid   <= 1'b1;
                            rsp_frame   <= rx;
                            rsp_timeout <= work_poll && !poll_hit;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: directed checks of framing, loopback capture, polling,
// FIFO back-pressure and mid-frame reset with two chip selects.
module tb_spi_cmd_master;
    import spi_cmd_pkg::*;

    localparam int CLK_DIV    = 5;
    localparam int NUM_CS     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int POLL_MAX   = 4;
    localparam int LEN        = 32;

    logic              clk_50M = 1'b0;
    logic              rst     = 1'b0;
    logic              sck;
    logic              mosi;
    logic              miso;
    logic [NUM_CS-1:0] cs_n;

    spi_cmd_if #(.LEN_SPI(LEN), .NUM_CS(NUM_CS)) bus ();

    spi_cmd_master #(
        .CLK_DIV    (CLK_DIV),
        .NUM_CS     (NUM_CS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .POLL_MAX   (POLL_MAX)
    ) dut (
        .clk_50M (clk_50M),
        .rst     (rst),
        .bus     (bus.slave),
        .sck     (sck),
        .mosi    (mosi),
        .miso    (miso),
        .cs_n    (cs_n)
    );

    // 50 MHz system clock.
    always #10 clk_50M = ~clk_50M;

    int checks = 0;
    int passes = 0;

    int             cs_low_cycles = 0;
    int             cs_windows    = 0;
    int             sck_falls     = 0;
    int             rsp_count     = 0;
    logic           prev_sck      = 1'b1;
    logic           prev_cs_low   = 1'b0;
    logic [LEN-1:0] tx_cap        = '0;
    logic [LEN-1:0] rsp_q[$];

    int miso_mode   = 0;
    int poll_window = 0;

    // Slave model: 0 = miso low, 1 = loopback, 2 = miso high only in one chosen window.
    assign miso = (miso_mode == 1) ? mosi :
                  (miso_mode == 2) ? (cs_windows == poll_window) : 1'b0;

    // Pin and response monitor sampled on the falling system-clock edge.
    always @(negedge clk_50M) begin
        if (cs_n != '1) begin
            cs_low_cycles <= cs_low_cycles + 1;
            if (!prev_cs_low) cs_windows <= cs_windows + 1;
        end
        prev_cs_low <= (cs_n != '1);
        if (prev_sck && !sck) begin
            sck_falls <= sck_falls + 1;
            tx_cap    <= {mosi, tx_cap[LEN-1:1]};
        end
        prev_sck <= sck;
        if (bus.rsp_valid) begin
            rsp_count <= rsp_count + 1;
            rsp_q.push_back(bus.rsp_frame);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [LEN-1:0] frame, input logic [0:0] sel,
                                 input logic poll, input logic [4:0] pbit);
        @(negedge clk_50M);
        bus.cmd_valid    = 1'b1;
        bus.cmd_frame    = frame;
        bus.cmd_cs_sel   = sel;
        bus.cmd_poll     = poll;
        bus.cmd_poll_bit = pbit;
        @(negedge clk_50M);
        bus.cmd_valid    = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk_50M);
            n++;
        end
        repeat (2) @(negedge clk_50M);
        checkOutput({tag, "_idle"}, bus.busy, 0);
    endtask

    int             c0, s0, r0, w0, q0;
    logic [5:0]     ready_seen;
    logic [LEN-1:0] obs;
    logic [LEN-1:0] exp_frame;

    initial begin
        bus.cmd_valid    = 1'b0;
        bus.cmd_frame    = '0;
        bus.cmd_cs_sel   = '0;
        bus.cmd_poll     = 1'b0;
        bus.cmd_poll_bit = '0;
        #5 rst = 1'b1;
        repeat (3) @(negedge clk_50M);
        checkOutput("rst_sck", sck, 1);
        checkOutput("rst_mosi", mosi, 0);
        checkOutput("rst_cs_n", cs_n, 2'b11);
        checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("rst_rsp_frame", bus.rsp_frame, 0);
        checkOutput("rst_rsp_timeout", bus.rsp_timeout, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk_50M);

        // Single frame: timing, bit order, one response.
        c0 = cs_low_cycles; s0 = sck_falls; r0 = rsp_count;
        applyStimulus(32'h2004_0000, 1'b0, 1'b0, 5'd0);
        waitIdle("t1", 4000);
        checkOutput("t1_cs_low_cycles", cs_low_cycles - c0, 330);
        checkOutput("t1_sck_falls", sck_falls - s0, 32);
        checkOutput("t1_mosi_bits", tx_cap, 32'h2004_0000);
        checkOutput("t1_rsp_count", rsp_count - r0, 1);
        checkOutput("t1_rsp_frame", bus.rsp_frame, 0);
        checkOutput("t1_rsp_timeout", bus.rsp_timeout, 0);

        // Loopback capture.
        miso_mode = 1;
        r0 = rsp_count;
        applyStimulus(32'h1008_6910, 1'b0, 1'b0, 5'd0);
        waitIdle("t2", 4000);
        checkOutput("t2_rsp_count", rsp_count - r0, 1);
        checkOutput("t2_rsp_frame", bus.rsp_frame, 32'h1008_6910);
        checkOutput("t2_rsp_timeout", bus.rsp_timeout, 0);

        // Poll success on the 4th attempt, which is also the attempt limit.
        miso_mode   = 2;
        poll_window = cs_windows + 4;
        w0 = cs_windows; r0 = rsp_count;
        applyStimulus(32'h0C0A_0000, 1'b0, 1'b1, 5'd0);
        waitIdle("t3", 4000);
        checkOutput("t3_windows", cs_windows - w0, 4);
        checkOutput("t3_rsp_count", rsp_count - r0, 1);
        checkOutput("t3_rsp_bit0", bus.rsp_frame[0], 1);
        checkOutput("t3_rsp_timeout", bus.rsp_timeout, 0);

        // Poll timeout with miso held low.
        miso_mode = 0;
        w0 = cs_windows; r0 = rsp_count;
        applyStimulus(make_frame(CMD_CB_OK_LOW, 10'd0, 16'd0), 1'b0, 1'b1, 5'd5);
        waitIdle("t4", 4000);
        checkOutput("t4_windows", cs_windows - w0, POLL_MAX);
        checkOutput("t4_rsp_count", rsp_count - r0, 1);
        checkOutput("t4_rsp_timeout", bus.rsp_timeout, 1);
        checkOutput("t4_rsp_frame", bus.rsp_frame, 0);

        // Six back-to-back pushes: five accepted, sixth dropped.
        miso_mode = 1;
        q0 = rsp_q.size(); r0 = rsp_count;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_50M);
            bus.cmd_valid  = 1'b1;
            bus.cmd_frame  = 32'hA500_0000 + 32'(k * 32'h0101);
            bus.cmd_cs_sel = 1'b0;
            bus.cmd_poll   = 1'b0;
            ready_seen[k]  = bus.cmd_ready;
        end
        @(negedge clk_50M);
        bus.cmd_valid = 1'b0;
        checkOutput("t5_ready_pattern", ready_seen, 6'b011111);
        waitIdle("t5", 6000);
        checkOutput("t5_rsp_count", rsp_count - r0, 5);
        for (int k = 0; k < 5; k++) begin
            exp_frame = 32'hA500_0000 + 32'(k * 32'h0101);
            obs = (rsp_q.size() > q0 + k) ? rsp_q[q0 + k] : 'x;
            checkOutput($sformatf("t5_order_%0d", k), obs, exp_frame);
        end

        // Reset in the middle of bit 10 on chip select 1.
        miso_mode = 0;
        s0 = sck_falls; r0 = rsp_count;
        applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0);
        begin
            int n = 0;
            while (sck_falls < s0 + 11 && n < 2000) begin
                @(negedge clk_50M);
                n++;
            end
        end
        checkOutput("t6_cs_sel1", cs_n, 2'b01);
        checkOutput("t6_mosi_before", mosi, 1);
        rst = 1'b1;
        #1;
        checkOutput("t6_sck", sck, 1);
        checkOutput("t6_cs_n", cs_n, 2'b11);
        checkOutput("t6_mosi", mosi, 0);
        checkOutput("t6_busy", bus.busy, 0);
        checkOutput("t6_rsp_valid", bus.rsp_valid, 0);
        repeat (3) @(negedge clk_50M);
        rst = 1'b0;
        w0 = cs_windows;
        repeat (400) @(negedge clk_50M);
        checkOutput("t6_no_rsp", rsp_count - r0, 0);
        checkOutput("t6_no_window", cs_windows - w0, 0);
        checkOutput("t6_idle_busy", bus.busy, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
- Synthesizable, parametrised SPI master that issues the NeuralLink command frames {CMD, ADDR, DATA} to the BMI digital top.
- Replaces the fixed 32-bit behavioural stimulus with RTL that adds:
  - a command FIFO;
  - a programmable SCK divider;
  - multiple chip selects;
  - a hardware poll-until-bit-set mode, used for CB_OK polling.
- Sits between the host/sequencer logic and the chip SPI pins.

Parameters:
- SPI_CODE_LEN, 6, command code width (frame MSBs).
- SPI_ADDR_LEN, 10, address width.
- SPI_DATA_LEN, 16, data width (frame LSBs).
- LEN_SPI, SPI_CODE_LEN+SPI_ADDR_LEN+SPI_DATA_LEN, total frame bits.
- CLK_DIV, 5, SCK half-period in clk_50M cycles (5 -> 5 MHz SCK). Must be >= 2.
- NUM_CS, 1, number of chip-select lines.
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >= 2).
- POLL_MAX, 255, maximum frame attempts per poll command (>= 1).

Ports:
- clk_50M  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command push request
- cmd_ready  out  1  FIFO not full
- cmd_frame  in  LEN_SPI  frame {code, addr, data}
- cmd_cs_sel  in  CSW=max(1,$clog2(NUM_CS))  target chip-select index
- cmd_poll  in  1  1 = repeat frame until the polled response bit is 1
- cmd_poll_bit  in  $clog2(LEN_SPI)  response bit index to poll
- rsp_valid  out  1  one-cycle pulse, response available
- rsp_frame  out  LEN_SPI  MISO bits captured in the last frame
- rsp_timeout  out  1  qualifies rsp_valid: poll hit POLL_MAX
- busy  out  1  frame or gap in progress, or FIFO non-empty
- sck  out  1  SPI clock, idles high
- mosi  out  1  SPI data out, idles 0
- miso  in  1  SPI data in
- cs_n  out  NUM_CS  chip selects, active low

Behaviour:
- **Reset values:** sck=1, mosi=0, cs_n=all 1, rsp_valid=0, rsp_frame=0, rsp_timeout=0, busy=0, FIFO empty, state IDLE.
- **Reset mid-frame:** the frame aborts immediately, the pins return to idle, and no response is emitted.
- **Push:** a push happens on clk_50M when cmd_valid && cmd_ready. Payload pushed: {cmd_frame, cmd_cs_sel, cmd_poll, cmd_poll_bit}.
- **cmd_ready:** equals !full. A push while full is ignored, even if a pop occurs in the same cycle.
- **Bit order:** LSB first. Bit i of the frame is the i-th bit shifted, so DATA[0] goes first and CODE MSB goes last.
- **Selector range:** cmd_cs_sel >= NUM_CS selects no line; the frame still clocks and still returns a response.
- **FSM states and transitions** (each timed phase lasts CLK_DIV cycles):
  - IDLE: if the FIFO is non-empty, pop the head into working registers, clear the attempt count, go to SETUP.
  - SETUP: cs_n[sel]=0, sck=1, mosi=frame[0].
  - LOW: sck=0. On the cycle sck goes 1->0, capture miso into rx[i]. At the end of the phase, go to HIGH.
  - HIGH: sck=1, mosi=frame[i+1]. After bit LEN_SPI-1, go to TAIL; otherwise return to LOW.
  - TAIL: sck=1, mosi=0, cs_n still low.
  - GAP: cs_n all high for CLK_DIV cycles.
- **Frame timing:** cs_n is low for CLK_DIV*(2*LEN_SPI+2) cycles per frame (330 cycles at defaults).
- **End of TAIL (attempt count incremented):**
  - Non-poll command: rsp_valid pulses with rsp_frame=rx and rsp_timeout=0, then go to GAP.
  - Poll command with rx[poll_bit]==1: rsp_valid pulses with rsp_timeout=0.
  - Poll command with attempts==POLL_MAX: rsp_valid pulses with rsp_timeout=1.
  - Poll command otherwise: no response; go to GAP, then SETUP with the same frame. The FIFO is not popped.
- **After GAP:** go to IDLE. Back-to-back commands are therefore always separated by one full GAP.
- **rsp_frame** holds its value until the next response.
- **Counters:**
  - The divider counter is $clog2(CLK_DIV) bits.
  - The bit index is $clog2(LEN_SPI) bits.
  - The attempt counter is $clog2(POLL_MAX+1) bits and saturates; it never wraps.
- **miso timing:** miso is sampled directly with no synchroniser, because the slave runs off sck.

Decomposition:
- Package spi_cmd_pkg holds:
  - the default widths;
  - localparams for the frame field offsets (DATA at 0, ADDR at SPI_DATA_LEN, CODE at SPI_DATA_LEN+SPI_ADDR_LEN);
  - the command code constants (0..24 per the CMD table, e.g. CMD_WRITE_REC=4, CMD_READ_STIM=3, CMD_CB_OK_LOW=18, CMD_READ_ADC=19);
  - the FSM state enum.
- Sub-module spi_cmd_fifo: synchronous FIFO, parametrised width and depth, with full/empty flags, async active-high reset, and pointers one bit wider than the address.

Test Plan:
- **Reset then single push:** rst pulses, then frame 0x20040000 (code 8, addr 4) with CLK_DIV=5. Required: cs_n low for exactly 330 cycles; 32 sck falling edges; mosi bits 18 and 29 are 1, all other bits 0; one rsp_valid.
- **Loopback:** miso tied to mosi, frame 0x10086910. Required: rsp_frame=0x10086910, rsp_timeout=0.
- **Poll success:** frame 0x0C0A0000 (code 3, addr {2,2}), poll_bit=0, and the slave model returns bit0=1 only on the 4th frame. Required: exactly 4 cs_n low windows, a single rsp_valid, rsp_frame[0]=1.
- **Poll timeout:** POLL_MAX=3, miso held at 0. Required: 3 frames, then rsp_valid with rsp_timeout=1 and rsp_frame=0.
- **FIFO full:** FIFO_DEPTH=4, 6 pushes in consecutive cycles. Required: cmd_ready drops after 5 accepted pushes (one popped immediately plus 4 stored), the 6th is ignored, and exactly 5 frames come out in order.
- **Mid-frame reset and chip select:** assert rst at bit 10 of a frame with NUM_CS=2, sel=1. Required: within the same cycle sck=1, cs_n=2'b11, mosi=0; no rsp_valid; busy=0.
